// File: rtl/tea_dram_pkg.sv
// Shared types and sizes for the TEA DRAM client: controller states,
// request record layout and the address/data/FIFO dimensions.
package tea_dram_pkg;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 64;
   localparam int FIFO_DEPTH = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      RD_RET  = 3'd3,
      WB_WAIT = 3'd4,
      WR_REQ  = 3'd5,
      WR_WAIT = 3'd6,
      FIN     = 3'd7
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rmw;
   } req_t;

endpackage

// File: rtl/tea_req_fifo.sv
// Small request FIFO holding {addr, rmw} records. The head is presented
// combinationally so the controller can decode it in the cycle it pops.
module tea_req_fifo
   import tea_dram_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  req_t push_data,
   input  logic pop,
   output req_t head,
   output logic empty,
   output logic full
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   req_t             slot [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   // A full FIFO never accepts, even if the head leaves in the same cycle.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = slot[rd_ptr];

   // Storage: write the incoming record at the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) slot[i] <= '0;
      end else if (push_ok) begin
         slot[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= bump(wr_ptr);
         if (pop_ok)  rd_ptr <= bump(rd_ptr);
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (!push_ok && pop_ok) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/tea_dram_client.sv
// DRAM client: queues datapath requests, reads a record through the bridge
// (or from the one-entry forward buffer), returns it, and optionally takes
// a write-back from the datapath and writes it to the bridge.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a queued request; pops head and checks forward hit
//   RD_REQ  | one-cycle bridge read command
//   RD_WAIT | waiting for bridge read data
//   RD_RET  | rd_valid pulse with the record
//   WB_WAIT | wb_ready high, waiting for the write-back data
//   WR_REQ  | one-cycle bridge write command, forward buffer updated
//   WR_WAIT | waiting for bridge write completion
//   FIN     | done pulse, request retired
module tea_dram_client
   import tea_dram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_rmw,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wb_valid,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic              done,
   output logic              C_in_valid,
   output logic              C_r_wb,
   output logic [ADDR_W-1:0] C_addr,
   output logic [DATA_W-1:0] C_data_w,
   input  logic              C_out_valid,
   input  logic [DATA_W-1:0] C_data_r
);

   state_t            state;
   state_t            state_nxt;
   req_t              head;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   logic              fwd_hit;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_rmw;
   logic [DATA_W-1:0] wb_buf;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_addr;
   logic [DATA_W-1:0] fwd_data;

   // req_ready is held low while reset is asserted so every output reads 0.
   assign req_ready = !fifo_full && !rst;
   assign pop       = (state == IDLE) && !fifo_empty;
   assign fwd_hit   = fwd_valid && (fwd_addr == head.addr);

   tea_req_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (req_valid && req_ready),
      .push_data ('{addr: req_addr, rmw: req_rmw}),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; bridge completions only matter in the two wait states.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!fifo_empty) state_nxt = fwd_hit ? RD_RET : RD_REQ;
         RD_REQ:  state_nxt = RD_WAIT;
         RD_WAIT: if (C_out_valid) state_nxt = RD_RET;
         RD_RET:  state_nxt = cur_rmw ? WB_WAIT : FIN;
         WB_WAIT: if (wb_valid) state_nxt = WR_REQ;
         WR_REQ:  state_nxt = WR_WAIT;
         WR_WAIT: if (C_out_valid) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs; bridge address/data stay at 0 whenever no command is issued.
   always_comb begin
      rd_valid   = 1'b0;
      wb_ready   = 1'b0;
      done       = 1'b0;
      C_in_valid = 1'b0;
      C_r_wb     = 1'b0;
      C_addr     = '0;
      C_data_w   = '0;
      case (state)
         RD_REQ: begin
            C_in_valid = 1'b1;
            C_r_wb     = 1'b1;
            C_addr     = cur_addr;
         end
         RD_RET:  rd_valid = 1'b1;
         WB_WAIT: wb_ready = 1'b1;
         WR_REQ: begin
            C_in_valid = 1'b1;
            C_addr     = cur_addr;
            C_data_w   = wb_buf;
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   // Capture the popped request so the FIFO slot can be refilled immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_addr <= '0;
         cur_rmw  <= 1'b0;
      end else if (pop) begin
         cur_addr <= head.addr;
         cur_rmw  <= head.rmw;
      end
   end

   // Read data register: forward-buffer data on a hit, bridge data on a miss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (pop && fwd_hit) begin
         rd_data <= fwd_data;
      end else if (state == RD_WAIT && C_out_valid) begin
         rd_data <= C_data_r;
      end
   end

   // Write-back data latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          wb_buf <= '0;
      else if (state == WB_WAIT && wb_valid) wb_buf <= wb_data;
   end

   // Forward buffer remembers the most recent write so a re-read skips the bridge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_data  <= '0;
      end else if (state == WR_REQ) begin
         fwd_valid <= 1'b1;
         fwd_addr  <= cur_addr;
         fwd_data  <= wb_buf;
      end
   end

endmodule

// File: tb/tb_tea_dram_client.sv
// Testbench for tea_dram_client: bridge memory model, write-back responder,
// scoreboard over a reference memory, directed vector table and random run.
module tb_tea_dram_client;
   import tea_dram_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_addr = '0;
   logic        req_rmw = 1'b0;
   logic        rd_valid;
   logic [63:0] rd_data;
   logic        wb_valid = 1'b0;
   logic [63:0] wb_data = '0;
   logic        wb_ready;
   logic        done;
   logic        C_in_valid;
   logic        C_r_wb;
   logic [7:0]  C_addr;
   logic [63:0] C_data_w;
   logic        C_out_valid = 1'b0;
   logic [63:0] C_data_r = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   tea_dram_client dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_rmw(req_rmw),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_ready(wb_ready),
      .done(done),
      .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
      .C_data_w(C_data_w), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- bridge model ----------------
   logic [63:0] bmem [256];
   logic [63:0] mmem [256];
   bit          br_pend = 0;
   bit          br_is_wr = 0;
   int          br_cnt = 0;
   logic [63:0] br_rdata = '0;
   int          br_lat_fixed = -1;
   bit          br_hold_wr = 0;
   bit          spur_req = 0;
   int          rresp_cyc = 0;
   int          wresp_cyc = 0;

   always @(negedge clk) begin
      C_out_valid = 1'b0;
      if (rst) begin
         br_pend = 0;
      end else begin
         if (br_pend) begin
            if (br_cnt == 0) begin
               if (!(br_is_wr && br_hold_wr)) begin
                  C_out_valid = 1'b1;
                  C_data_r    = br_rdata;
                  if (br_is_wr) wresp_cyc = cyc;
                  else          rresp_cyc = cyc;
                  br_pend = 0;
               end
            end else begin
               br_cnt--;
            end
         end else if (spur_req) begin
            C_out_valid = 1'b1;
            C_data_r    = 64'hBAD0_BAD0_BAD0_BAD0;
            spur_req    = 0;
         end
         if (C_in_valid) begin
            br_pend  = 1;
            br_is_wr = !C_r_wb;
            br_cnt   = (br_lat_fixed >= 0) ? br_lat_fixed : int'($urandom_range(0, 4));
            if (C_r_wb) begin
               br_rdata = bmem[C_addr];
            end else begin
               bmem[C_addr] = C_data_w;
               br_rdata = {$urandom, $urandom};
            end
         end
      end
   end

   // ---------------- write-back responder ----------------
   int          wb_dly_fixed = -1;
   bit          wb_hold = 0;
   int          wb_cnt = -1;
   logic [63:0] wbq [$];

   always @(negedge clk) begin
      wb_valid = 1'b0;
      if (rst) begin
         wb_cnt = -1;
      end else if (wb_ready && !wb_hold) begin
         if (wb_cnt < 0)
            wb_cnt = (wb_dly_fixed >= 0) ? wb_dly_fixed : int'($urandom_range(0, 3));
         if (wb_cnt == 0) begin
            wb_valid = 1'b1;
            wb_data  = (wbq.size() > 0) ? wbq.pop_front() : 64'h0;
            wb_cnt   = -1;
         end else begin
            wb_cnt--;
         end
      end
   end

   // ---------------- monitor and scoreboard ----------------
   typedef struct {
      logic [7:0]  addr;
      logic        rmw;
      logic [63:0] wbd;
   } exp_t;
   exp_t        expq [$];
   bit          fwd_v = 0;
   logic [7:0]  fwd_a = '0;
   int          exp_reads = 0, exp_writes = 0;
   int          nreads = 0, nwrites = 0, nrd = 0, ndone = 0;
   int          civ_cyc = 0, rd_cyc = 0, done_cyc = 0;
   logic [63:0] rd_last = '0;
   logic [7:0]  wr_addr_last = '0;
   logic [63:0] wr_data_last = '0;
   bit          prev_civ = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_civ = 0;
      end else begin
         chk("bridge_protocol",
             64'((C_in_valid && prev_civ) || (!C_in_valid && (C_addr != 0 || C_data_w != 0))), 64'd0);
         prev_civ = C_in_valid;
         if (C_in_valid) begin
            if (C_r_wb) begin
               nreads++;
               civ_cyc = cyc;
            end else begin
               nwrites++;
               wr_addr_last = C_addr;
               wr_data_last = C_data_w;
            end
         end
         if (rd_valid) begin
            nrd++;
            rd_cyc  = cyc;
            rd_last = rd_data;
            if (expq.size() == 0) begin
               chk_i("sb_unexpected_rd", 1, 0);
            end else begin
               if (!(fwd_v && fwd_a == expq[0].addr)) exp_reads++;
               chk("sb_rd_data", rd_data, mmem[expq[0].addr]);
            end
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            if (expq.size() == 0) begin
               chk_i("sb_unexpected_done", 1, 0);
            end else begin
               if (expq[0].rmw) begin
                  mmem[expq[0].addr] = expq[0].wbd;
                  fwd_v = 1;
                  fwd_a = expq[0].addr;
                  exp_writes++;
               end
               void'(expq.pop_front());
               chk_i("sb_read_count", nreads, exp_reads);
               chk_i("sb_write_count", nwrites, exp_writes);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_req(input logic [7:0] a, input logic r, input logic [63:0] wd,
                           output int acc_cyc);
      bit rdy;
      bit ok;
      ok = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_rmw   = r;
      for (int n = 0; n < 200; n++) begin
         rdy = req_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1;
            break;
         end
         #1;
      end
      acc_cyc = cyc;
      if (!ok) chk_i("push_timeout", 0, 1);
      else begin
         expq.push_back('{addr: a, rmw: r, wbd: wd});
         if (r) wbq.push_back(wd);
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (ndone < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      #2;
      chk_i(tag, ndone, target);
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic        rmw;
      logic [63:0] wbd;
      bit          hit;
      logic [63:0] exp_rd;
   } vec_t;

   vec_t        vecs [8];
   int          pc, r0, w0, d0, nrd0, k;
   logic [7:0]  ra;
   logic        rr;
   logic [63:0] rw;

   initial begin
      for (int i = 0; i < 256; i++) begin
         bmem[i] = {32'hC0DE_0000 | 32'(i), 32'h1234_5678 ^ 32'(i)};
         mmem[i] = bmem[i];
      end
      bmem[8'h12] = 64'hDEAD_BEEF_0000_0001;  mmem[8'h12] = 64'hDEAD_BEEF_0000_0001;
      bmem[8'h05] = 64'h11;                   mmem[8'h05] = 64'h11;

      vecs[0] = '{8'h12, 1'b0, 64'h0,    1'b0, 64'hDEAD_BEEF_0000_0001};
      vecs[1] = '{8'h05, 1'b1, 64'h22,   1'b0, 64'h11};
      vecs[2] = '{8'h05, 1'b0, 64'h0,    1'b1, 64'h22};
      vecs[3] = '{8'h12, 1'b0, 64'h0,    1'b0, 64'hDEAD_BEEF_0000_0001};
      vecs[4] = '{8'h05, 1'b1, 64'h33,   1'b1, 64'h22};
      vecs[5] = '{8'h05, 1'b0, 64'h0,    1'b1, 64'h33};
      vecs[6] = '{8'h07, 1'b1, 64'hABCD, 1'b0, 64'hC0DE_0007_1234_567F};
      vecs[7] = '{8'h05, 1'b0, 64'h0,    1'b0, 64'h33};

      // reset state
      step(3);
      chk("rst_ctrl_outputs", 64'({req_ready, rd_valid, wb_ready, done, C_in_valid, C_r_wb}), 64'd0);
      chk("rst_c_addr", 64'(C_addr), 64'd0);
      chk("rst_c_data_w", C_data_w, 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(req_ready), 64'd1);
      chk("rd_data_after_rst", rd_data, 64'd0);
      step(1);

      // directed vector table: miss, rmw, forward hit, hit-with-rmw, eviction
      br_lat_fixed = 2;
      wb_dly_fixed = 3;
      for (int i = 0; i < 8; i++) begin
         r0 = nreads; w0 = nwrites; d0 = ndone;
         push_req(vecs[i].addr, vecs[i].rmw, vecs[i].wbd, pc);
         wait_done(d0 + 1, 100, "vec_done");
         chk("vec_rd_data", rd_last, vecs[i].exp_rd);
         chk_i("vec_bridge_reads", nreads - r0, vecs[i].hit ? 0 : 1);
         chk_i("vec_bridge_writes", nwrites - w0, vecs[i].rmw ? 1 : 0);
         if (vecs[i].hit) begin
            chk_i("vec_hit_latency", rd_cyc, pc + 1);
         end else begin
            chk_i("vec_read_issue_cycle", civ_cyc, pc + 1);
            chk_i("vec_miss_rd_latency", rd_cyc, rresp_cyc + 1);
         end
         if (vecs[i].rmw) begin
            chk_i("vec_done_after_write", done_cyc, wresp_cyc + 1);
            chk("vec_write_addr", 64'(wr_addr_last), 64'(vecs[i].addr));
            chk("vec_write_data", wr_data_last, vecs[i].wbd);
         end else begin
            chk_i("vec_done_after_rd", done_cyc, rd_cyc + 1);
         end
         step(1);
      end

      // back-pressure: three pushes while busy, third refused, all retire in order
      br_lat_fixed = 3;
      wb_dly_fixed = 0;
      d0 = ndone;
      push_req(8'h50, 1'b0, 64'h0, pc);
      push_req(8'h51, 1'b1, 64'h5151, pc);
      push_req(8'h52, 1'b0, 64'h0, pc);
      req_valid = 1'b1;
      req_addr  = 8'h53;
      req_rmw   = 1'b0;
      chk("bp_ready_low_third", 64'(req_ready), 64'd0);
      push_req(8'h53, 1'b0, 64'h0, pc);
      wait_done(d0 + 4, 200, "bp_all_done");
      chk("bp_last_rd", rd_last, mmem[8'h53]);
      step(2);

      // reset during WR_WAIT
      br_hold_wr = 1;
      w0 = nwrites;
      push_req(8'h40, 1'b1, 64'h77, pc);
      k = 0;
      while (nwrites == w0 && k < 100) begin
         step(1);
         k++;
      end
      chk_i("wr_pulse_seen", nwrites, w0 + 1);
      step(1);
      rst = 1'b1;
      #1;
      chk("midrst_ctrl_outputs", 64'({req_ready, rd_valid, wb_ready, done, C_in_valid, C_r_wb}), 64'd0);
      chk("midrst_rd_data", rd_data, 64'd0);
      w0 = nwrites;
      r0 = nreads;
      expq.delete();
      wbq.delete();
      fwd_v = 0;
      mmem[8'h40] = 64'h77;
      exp_writes++;
      br_hold_wr = 0;
      step(2);
      rst = 1'b0;
      #1;
      chk("ready_after_midrst", 64'(req_ready), 64'd1);
      step(3);
      chk_i("no_write_after_rst", nwrites, w0);
      d0 = ndone;
      push_req(8'h40, 1'b0, 64'h0, pc);
      wait_done(d0 + 1, 100, "post_rst_done");
      chk_i("post_rst_bridge_read", nreads, r0 + 1);
      chk("post_rst_rd_data", rd_last, 64'h77);
      step(1);

      // spurious completion while idle
      nrd0 = nrd; d0 = ndone;
      spur_req = 1;
      step(3);
      chk_i("spur_idle_no_rd", nrd, nrd0);
      chk_i("spur_idle_no_done", ndone, d0);
      push_req(8'h30, 1'b0, 64'h0, pc);
      wait_done(d0 + 1, 100, "spur_idle_next_done");
      chk_i("spur_idle_next_issue", civ_cyc, pc + 1);

      // spurious completion in WB_WAIT
      wb_hold = 1;
      d0 = ndone;
      push_req(8'h31, 1'b1, 64'h55, pc);
      k = 0;
      while (!wb_ready && k < 100) begin
         step(1);
         k++;
      end
      chk("wbwait_reached", 64'(wb_ready), 64'd1);
      nrd0 = nrd;
      spur_req = 1;
      step(3);
      chk("spur_wb_still_waiting", 64'(wb_ready), 64'd1);
      chk_i("spur_wb_no_done", ndone, d0);
      chk_i("spur_wb_no_rd", nrd, nrd0);
      wb_hold = 0;
      wait_done(d0 + 1, 100, "spur_wb_done");
      chk("spur_wb_write_data", wr_data_last, 64'h55);

      // randomized traffic checked by the scoreboard
      br_lat_fixed = -1;
      wb_dly_fixed = -1;
      d0 = ndone;
      for (int i = 0; i < 80; i++) begin
         ra = 8'h60 + 8'($urandom_range(0, 7));
         rr = 1'($urandom_range(0, 1));
         rw = {$urandom, $urandom};
         push_req(ra, rr, rw, pc);
         step(int'($urandom_range(0, 3)));
      end
      wait_done(d0 + 80, 3000, "rand_all_done");
      chk_i("rand_queue_empty", expq.size(), 0);
      chk_i("rand_reads", nreads, exp_reads);
      chk_i("rand_writes", nwrites, exp_writes);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tea_dram_client.md
TEA_DRAM_CLIENT -- requirements
Module: tea_dram_client

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  datapath offers access request; req_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: req_addr  in  8  record index; req_rmw  in  1  1 = read then write-back, 0 = read only.
REQ-005 SHALL have ports: rd_valid  out  1  one-cycle pulse, rd_data valid; rd_data  out  64  record read.
REQ-006 SHALL have ports: wb_valid  in  1; wb_data  in  64; wb_ready  out  1  write-back handshake.
REQ-007 SHALL have ports: done  out  1  one-cycle pulse, request fully retired.
REQ-008 SHALL have bridge-side ports: C_in_valid  out  1; C_r_wb  out  1 (1 = read); C_addr  out  8; C_data_w  out  64; C_out_valid  in  1; C_data_r  in  64.

Function
REQ-009 SHALL buffer requests in a 2-entry FIFO of {addr, rmw}; req_ready = FIFO not full; push and pop in the same cycle SHALL be legal at count 1; at count 2, no push occurs.
REQ-010 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, RD_RET, WB_WAIT, WR_REQ, WR_WAIT, FIN.
REQ-011 IDLE: FIFO non-empty -> pop head; forward hit -> RD_RET, else -> RD_REQ.
REQ-012 RD_REQ: C_in_valid=1, C_r_wb=1, C_addr=head addr for exactly one cycle -> RD_WAIT.
REQ-013 RD_WAIT: on C_out_valid, latch C_data_r into rd_data -> RD_RET.
REQ-014 RD_RET: rd_valid=1 for one cycle; rmw=1 -> WB_WAIT, rmw=0 -> FIN.
REQ-015 WB_WAIT: wb_ready=1; on wb_valid, latch wb_data -> WR_REQ; no timeout.
REQ-016 WR_REQ: C_in_valid=1, C_r_wb=0, C_addr=head addr, C_data_w=latched data for one cycle; update forward buffer {valid=1, addr, data} -> WR_WAIT.
REQ-017 WR_WAIT: on C_out_valid -> FIN; FIN: done=1 for one cycle -> IDLE.
REQ-018 Forward hit = forward buffer valid and addr equal to popped addr; hit SHALL issue no bridge read and SHALL return the buffered data in RD_RET (rd_valid 1 cycle after pop).
REQ-019 C_in_valid SHALL never be asserted in two consecutive cycles; C_addr/C_data_w SHALL be 0 when C_in_valid=0.
REQ-020 C_out_valid in any state other than RD_WAIT/WR_WAIT SHALL be ignored.
REQ-021 rd_data SHALL hold its value until the next RD_RET; wb_ready SHALL be 0 outside WB_WAIT.
REQ-022 Miss latency: pop at cycle t -> C_in_valid at t+1 -> rd_valid one cycle after C_out_valid.

Reset
REQ-023 On rst: FSM=IDLE, FIFO empty, forward buffer invalid, all outputs 0 (req_ready reads 1 once rst deasserts).
REQ-024 Reset mid-transaction SHALL abort it without any further C_in_valid pulse; the in-flight request is lost.

Structure
REQ-025 Package tea_dram_pkg SHALL hold the state enum, ADDR_W=8, DATA_W=64, FIFO_DEPTH=2.
REQ-026 The request FIFO SHALL be sub-module tea_req_fifo; the FSM and forward buffer stay in the top level.

Verification
REQ-027 Read-only miss: push addr 0x12 rmw=0, bridge returns 0xDEAD_BEEF_0000_0001 -> one read pulse C_addr=0x12, rd_valid with that data, done next cycle.
REQ-028 RMW: push 0x05 rmw=1, read 0x11, wb_data 0x22 after 3 cycles -> write pulse C_r_wb=0, C_addr=0x05, C_data_w=0x22, done after write C_out_valid.
REQ-029 Forward: after REQ-028, push 0x05 rmw=0 -> no C_in_valid, rd_valid with data 0x22 one cycle after pop.
REQ-030 Back-pressure: push 3 requests back-to-back while busy -> req_ready low on third attempt; all three retire in order.
REQ-031 Reset during WR_WAIT -> outputs 0 at once, no write pulse, next request to the same addr issues a bridge read.
REQ-032 Spurious C_out_valid in IDLE and WB_WAIT -> no state change, no rd_valid or done.
